alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one instance of the team's 4-bit `alu` combinational block between two requesters (port 0, port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with one request accepted per cycle.
- Each port has a one-entry registered response slot, and the block keeps a saturating count of invalid opcodes.

Parameters:
- CNT_W, 8, width of the invalid-op counter err_cnt_o (≥2).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset: asynchronous assert, active-low.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle (combinational).
- req0_a_i  in  4  port 0 operand A.
- req0_b_i  in  4  port 0 operand B.
- req0_op_i  in  4  port 0 opcode.
- rsp0_valid_o  out  1  port 0 response valid.
- rsp0_ready_i  in  1  port 0 response consumed.
- rsp0_result_o  out  4  port 0 result.
- rsp0_err_o  out  1  port 0 opcode was invalid (>0xA).
- req1_*, rsp1_*  as port 0, for port 1.
- err_cnt_o  out  CNT_W  saturating count of accepted invalid ops.

Behaviour:
- ALU semantics (mod 16; >0xA gives result 0, err=1):
  - 0 a+b, 1 a-b, 2 a&b, 3 a|b, 4 a^b
  - 5 a, 6 b, 7 -a, 8 -b, 9 ~a, A ~b
- Reset (rst_ni=0, asynchronous, any cycle including mid-transaction):
  - Outputs: rsp*_valid_o=0, rsp*_result_o=0, rsp*_err_o=0, err_cnt_o=0.
  - Internal state: priority pointer=0 (port 0 favoured).
  - In-flight requests and unconsumed responses are discarded.
  - req*_ready_o=0 while in reset.
- Eligibility: port i is eligible when req{i}_valid_i=1 AND slot i is free.
  - Slot i is free when rsp{i}_valid_o=0, or rsp{i}_valid_o=1 with rsp{i}_ready_i=1 (same-cycle drain-and-refill allowed).
- Grant: at most one port per cycle.
  - One port eligible: grant it.
  - Both eligible: grant the port indicated by the priority pointer.
  - After any grant, the pointer moves to the other port. With no grant, it is unchanged.
- req{i}_ready_o is 1 exactly when port i is granted.
  - It is combinational from valid, slot state, rsp_ready and the pointer.
  - It must not depend on req_a/b/op.
- Acceptance: on a cycle with req{i}_valid_i & req{i}_ready_o, the ALU operands/op are muxed from port i.
  - Next edge: rsp{i}_result_o and rsp{i}_err_o load the ALU outputs and rsp{i}_valid_o=1.
  - Latency is 1 cycle from accept to response valid.
- Response hold: while rsp{i}_valid_o=1 and rsp{i}_ready_i=0, result and err are stable.
  - rsp{i}_valid_o clears on the edge where rsp{i}_ready_i=1, unless refilled that same cycle.
- Result/err registers keep their last value when valid=0 (no need to clear).
- Throughput:
  - A single active port with rsp_ready held 1 achieves one op per cycle.
  - Two active ports alternate, each getting one op every 2 cycles.
  - No port waits more than 1 grant while eligible (starvation-free).
- err_cnt_o increments by 1 on each accepted request with op>0xA and saturates at 2^CNT_W-1.
  - Only accepted requests are counted; unaccepted invalid requests are not.
- Requesters must hold a/b/op stable while valid=1 and ready=0. The block does not check this.

Test Plan:
- Reset, then port 0 sends a=3, b=5, op=0 with rsp0_ready_i=1:
  - req0_ready_o=1 in the same cycle.
  - The next cycle shows rsp0_valid_o=1, result=0x8, err=0.
- Both ports valid every cycle, op0=1 (a=2, b=3), op1=7 (a=1), rsp ready=1:
  - Grants go 0,1,0,1.
  - Port 0 results are 0xF; port 1 results are 0xF.
  - Each port gets ready on alternate cycles.
- Port 1 response stalled (rsp1_ready_i=0) with a result pending, and port 1 valid again:
  - req1_ready_o stays 0 and rsp1_result_o is stable.
  - Port 0 gets every grant.
  - Raising rsp1_ready_i gives same-cycle drain and accept, so rsp1_valid_o stays 1 with the new result.
- Op sweep 0x0–0xF on port 0 with a=0x9, b=0x6:
  - Results F,3,0,F,F,9,6,7,A,6,9, then 0 for op B–F.
  - err=1 for op B–F.
  - err_cnt_o=5.
- CNT_W=2, 5 accepted invalid ops: err_cnt_o goes 1,2,3,3,3.
- Assert rst_ni low mid-stream with rsp0_valid_o=1 and port 1 pending:
  - All valids drop immediately (asynchronous) and err_cnt_o=0.
  - After release, first simultaneous request is granted to port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 4-bit ALU.
//   Arbitration is round-robin, with at most one accept per cycle.
//   Each port has a one-entry registered response slot.
//   A saturating counter tracks accepted invalid opcodes.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req{0,1}_valid_i/a_i/b_i/op_i, req{0,1}_ready_o   request channels
//     (ready is combinational)
//   rsp{0,1}_valid_o/result_o/err_o, rsp{0,1}_ready_i response channels
//   err_cnt_o              saturating count of accepted ops with op > 0xA
module alu_arbiter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [3:0]       req0_a_i,
   input  logic [3:0]       req0_b_i,
   input  logic [3:0]       req0_op_i,
   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [3:0]       rsp0_result_o,
   output logic             rsp0_err_o,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [3:0]       req1_a_i,
   input  logic [3:0]       req1_b_i,
   input  logic [3:0]       req1_op_i,
   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [3:0]       rsp1_result_o,
   output logic             rsp1_err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int unsigned DW = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic          ptr;          // 0: port 0 favoured on a tie
   logic          elig0, elig1;
   logic          gnt0, gnt1;
   logic [DW-1:0] alu_a, alu_b, alu_op, alu_res;
   logic          alu_err;

   // A slot is free when empty or being drained this cycle; reset masks eligibility.
   assign elig0 = rst_ni & req0_valid_i & (~rsp0_valid_o | rsp0_ready_i);
   assign elig1 = rst_ni & req1_valid_i & (~rsp1_valid_o | rsp1_ready_i);

   // Round-robin: a lone eligible port wins, a tie goes to the pointer.
   assign gnt0 = elig0 & (~elig1 | ~ptr);
   assign gnt1 = elig1 & (~elig0 |  ptr);

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   // Operand mux: port 1 only when it holds the grant.
   always_comb begin
      alu_a  = req0_a_i;
      alu_b  = req0_b_i;
      alu_op = req0_op_i;
      if (gnt1) begin
         alu_a  = req1_a_i;
         alu_b  = req1_b_i;
         alu_op = req1_op_i;
      end
   end

   // Shared combinational ALU, all arithmetic mod 16.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (alu_op)
         4'h0:    alu_res = alu_a + alu_b;
         4'h1:    alu_res = alu_a - alu_b;
         4'h2:    alu_res = alu_a & alu_b;
         4'h3:    alu_res = alu_a | alu_b;
         4'h4:    alu_res = alu_a ^ alu_b;
         4'h5:    alu_res = alu_a;
         4'h6:    alu_res = alu_b;
         4'h7:    alu_res = DW'(0) - alu_a;
         4'h8:    alu_res = DW'(0) - alu_b;
         4'h9:    alu_res = ~alu_a;
         4'hA:    alu_res = ~alu_b;
         default: alu_err = 1'b1;
      endcase
   end

   // Priority pointer flips to the other port after any grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= 1'b0;
      end else if (gnt0) begin
         ptr <= 1'b1;
      end else if (gnt1) begin
         ptr <= 1'b0;
      end
   end

   // Port 0 response slot: a refill wins over a drain in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp0_valid_o  <= 1'b0;
         rsp0_result_o <= '0;
         rsp0_err_o    <= 1'b0;
      end else if (gnt0) begin
         rsp0_valid_o  <= 1'b1;
         rsp0_result_o <= alu_res;
         rsp0_err_o    <= alu_err;
      end else if (rsp0_ready_i) begin
         rsp0_valid_o  <= 1'b0;
      end
   end

   // Port 1 response slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp1_valid_o  <= 1'b0;
         rsp1_result_o <= '0;
         rsp1_err_o    <= 1'b0;
      end else if (gnt1) begin
         rsp1_valid_o  <= 1'b1;
         rsp1_result_o <= alu_res;
         rsp1_err_o    <= alu_err;
      end else if (rsp1_ready_i) begin
         rsp1_valid_o  <= 1'b0;
      end
   end

   // Saturating count of accepted invalid opcodes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_o <= '0;
      end else if ((gnt0 | gnt1) && alu_err && (err_cnt_o != CNT_MAX)) begin
         err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
   end

endmodule
